stream_mux_2to1: RTL and testbench
==================================

Name: stream_mux_2to1

Overview:
Packet-aware 2:1 stream multiplexer with valid/ready handshakes on both inputs and the output. It arbitrates round-robin between source A and source B and holds the grant for a whole packet, up to and including the beat with last=1. It registers the selected beat into a single output stage. It also exports the registered select, which downstream 2:1 data muxes and bookkeeping logic use as their s input.

Parameters:
DATA_W, 8, width of a_data/b_data/y_data in bits

Ports:
clk  input  1  system clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
a_valid  input  1  source A beat valid
a_data  input  DATA_W  source A beat payload
a_last  input  1  source A end-of-packet marker
a_ready  output  1  source A beat accepted this cycle when a_valid&a_ready
b_valid  input  1  source B beat valid
b_data  input  DATA_W  source B beat payload
b_last  input  1  source B end-of-packet marker
b_ready  output  1  source B beat accepted this cycle when b_valid&b_ready
y_valid  output  1  output beat valid
y_data  output  DATA_W  output payload
y_last  output  1  output end-of-packet marker
y_ready  input  1  downstream ready
sel  output  1  source of the beat in the output register; 0=A, 1=B
busy  output  1  high while a packet is locked (state != IDLE)

Behaviour:
- Reset (rst_n=0, async): y_valid=0, y_data=0, y_last=0, sel=0, state=IDLE, rr=0 (A has priority first), a_ready=0, b_ready=0.
- Definition: load_ok = !y_valid | y_ready. The output register accepts a new beat in any cycle where load_ok=1.
- Throughput and latency: 1 beat/cycle; 1-cycle latency from input handshake to y_valid.
- No combinational path from y_ready to y_valid/y_data.
- States:
  - IDLE: no packet locked.
  - LOCK_A: A owns the output until its last beat.
  - LOCK_B: B owns the output until its last beat.
- IDLE grant selection:
  - Only a_valid high: grant A.
  - Only b_valid high: grant B.
  - Both high: grant A if rr=0, otherwise B.
  - Neither high: no grant.
- IDLE handshake:
  - Granted side's ready = load_ok; the other side's ready = 0.
  - On a handshake with last=0: go to LOCK_x.
  - On a handshake with last=1 (single-beat packet): stay in IDLE.
  - If load_ok=0: no handshake, no state change, and the grant is re-evaluated next cycle.
- LOCK_A: a_ready=load_ok, b_ready=0. The handshake beat with a_last=1 returns to IDLE. a_valid may drop mid-packet; this inserts a bubble and the lock is held.
- LOCK_B: mirror of LOCK_A.
- rr update: on every accepted last beat, rr <= ~(source of that packet), so the other source gets priority next.
- Output register load (on handshake): y_data<=selected data, y_last<=selected last, sel<=source, y_valid<=1.
- Output drain: y_valid<=0 when y_valid&y_ready and no new handshake that cycle. sel holds its value while y_valid=0.
- Simultaneous drain and load: a downstream handshake and an upstream handshake in the same cycle give a seamless back-to-back beat, with y_valid staying 1.
- Ready dependencies: a_ready/b_ready may depend combinationally on a_valid, b_valid and y_ready. They never depend on a_data/b_data.
- Reset mid-packet: the lock is abandoned and the output beat is dropped. Upstream is responsible for flushing its partial packet under the same reset.
- Invariant: a_ready&b_ready is never 1.

Decomposition:
- Package stream_mux_pkg holds:
  - state enum: IDLE, LOCK_A, LOCK_B
  - constants SRC_A=1'b0, SRC_B=1'b1
- Sub-module rr_arb2 (combinational): inputs req[1:0], rr → output grant_src and grant_vld. It is reused wherever two-way fair arbitration is needed.
- Top level holds the FSM, rr flop and output register.

Test Plan:
- Single source, single-beat packets:
  - Stimulus: A only, y_ready=1, a_data=8'h11,8'h22,8'h33 each with a_last=1.
  - Required: y_data=11,22,33 on consecutive cycles, 1 cycle after each accept; sel=0; busy never 1.
- Contention, round-robin:
  - Stimulus: A and B both continuously valid, single-beat packets (A=8'hA0.., B=8'hB0..), y_ready=1.
  - Required: output alternates A0,B0,A1,B1; first beat from A (rr=0 after reset); sel toggles 0,1,0,1.
- Packet lock:
  - Stimulus: A sends 3 beats (last on 3rd) while B is valid from cycle 0.
  - Required: b_ready=0 until A's last beat is accepted; then B's beat follows immediately; busy=1 during A's beats 1-2.
- Backpressure:
  - Stimulus: y_ready=0 for 4 cycles with y_valid=1.
  - Required: y_data/y_last/sel stable; a_ready=b_ready=0; no beat lost or duplicated after y_ready returns to 1.
- Bubble inside a packet:
  - Stimulus: a_valid drops for 2 cycles mid-packet while B is valid.
  - Required: lock held (busy=1, b_ready=0); packet resumes on A.
- Async reset mid-packet:
  - Stimulus: assert rst_n=0 between clock edges during LOCK_B.
  - Required: y_valid=0, sel=0, busy=0 immediately; after release, the first grant goes to A when both sources are valid.

Source files
------------

// File: rtl/stream_mux_pkg.sv
// Shared types and constants for the packet-aware 2:1 stream multiplexer.
// Source encoding matches the exported sel output: 0 = A, 1 = B.
package stream_mux_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCK_A = 2'd1,
        LOCK_B = 2'd2
    } state_t;

    localparam logic SRC_A = 1'b0;
    localparam logic SRC_B = 1'b1;

    // Convert a source id into the lock state that holds it.
    function automatic state_t lock_state_of(input logic src);
        return (src == SRC_B) ? LOCK_B : LOCK_A;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: a lone requester always wins,
// and a tie goes to the side that rr currently favours.
import stream_mux_pkg::*;

module rr_arb2 (
    input  logic [1:0] req,
    input  logic       rr,
    output logic       grant_src,
    output logic       grant_vld
);

    always_comb begin
        grant_src = SRC_A;
        grant_vld = 1'b0;
        case (req)
            2'b01: begin
                grant_src = SRC_A;
                grant_vld = 1'b1;
            end
            2'b10: begin
                grant_src = SRC_B;
                grant_vld = 1'b1;
            end
            2'b11: begin
                grant_src = rr ? SRC_B : SRC_A;
                grant_vld = 1'b1;
            end
            default: begin
                grant_src = SRC_A;
                grant_vld = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/stream_mux_2to1.sv
// Packet-aware 2:1 stream mux: round-robin grant held for a whole packet,
// single registered output stage, registered select exported as sel.
import stream_mux_pkg::*;

module stream_mux_2to1 #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_valid,
    input  logic [DATA_W-1:0] a_data,
    input  logic              a_last,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [DATA_W-1:0] b_data,
    input  logic              b_last,
    output logic              b_ready,
    output logic              y_valid,
    output logic [DATA_W-1:0] y_data,
    output logic              y_last,
    input  logic              y_ready,
    output logic              sel,
    output logic              busy
);

    state_t              r_state;
    state_t              w_state_next;
    logic                r_rr;
    logic                w_rr_next;
    logic                r_y_valid;
    logic [DATA_W-1:0]   r_y_data;
    logic                r_y_last;
    logic                r_sel;

    logic                w_load_ok;
    logic                w_grant_src;
    logic                w_grant_vld;
    logic                w_a_ready;
    logic                w_b_ready;
    logic                w_a_hs;
    logic                w_b_hs;
    logic                w_hs;
    logic                w_src;
    logic                w_last;
    logic [DATA_W-1:0]   w_data;

    // The output stage can take a beat when empty or when it drains this cycle.
    assign w_load_ok = !r_y_valid || y_ready;

    rr_arb2 u_arb (
        .req       ({b_valid, a_valid}),
        .rr        (r_rr),
        .grant_src (w_grant_src),
        .grant_vld (w_grant_vld)
    );

    always_comb begin
        w_a_ready = 1'b0;
        w_b_ready = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_grant_vld) begin
                    if (w_grant_src == SRC_A) begin
                        w_a_ready = w_load_ok;
                    end else begin
                        w_b_ready = w_load_ok;
                    end
                end
            end
            LOCK_A: w_a_ready = w_load_ok;
            LOCK_B: w_b_ready = w_load_ok;
            default: begin
                w_a_ready = 1'b0;
                w_b_ready = 1'b0;
            end
        endcase
        // Nothing is accepted while the block is held in reset.
        if (!rst_n) begin
            w_a_ready = 1'b0;
            w_b_ready = 1'b0;
        end
    end

    assign w_a_hs = a_valid && w_a_ready;
    assign w_b_hs = b_valid && w_b_ready;
    assign w_hs   = w_a_hs || w_b_hs;

    always_comb begin
        w_src  = w_b_hs ? SRC_B : SRC_A;
        w_data = w_b_hs ? b_data : a_data;
        w_last = w_b_hs ? b_last : a_last;
    end

    always_comb begin
        w_state_next = r_state;
        w_rr_next    = r_rr;
        if (w_hs) begin
            if (w_last) begin
                w_state_next = IDLE;
                w_rr_next    = ~w_src;
            end else begin
                w_state_next = lock_state_of(w_src);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_rr    <= SRC_A;
        end else begin
            r_state <= w_state_next;
            r_rr    <= w_rr_next;
        end
    end

    // A same-cycle drain and load keeps y_valid high for back-to-back beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_y_valid <= 1'b0;
            r_y_data  <= '0;
            r_y_last  <= 1'b0;
            r_sel     <= SRC_A;
        end else if (w_hs) begin
            r_y_valid <= 1'b1;
            r_y_data  <= w_data;
            r_y_last  <= w_last;
            r_sel     <= w_src;
        end else if (r_y_valid && y_ready) begin
            r_y_valid <= 1'b0;
        end
    end

    assign a_ready = w_a_ready;
    assign b_ready = w_b_ready;
    assign y_valid = r_y_valid;
    assign y_data  = r_y_data;
    assign y_last  = r_y_last;
    assign sel     = r_sel;
    assign busy    = (r_state != IDLE);

endmodule

// File: tb/tb_stream_mux_2to1.sv
// Bench for stream_mux_2to1: directed vector table, hand-written corner
// sequences, then random traffic against a rule-level reference model.
module tb_stream_mux_2to1;

    localparam int DATA_W = 8;
    localparam int NV     = 21;
    localparam int NRAND  = 3000;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              a_valid, a_last, b_valid, b_last, y_ready;
    logic [DATA_W-1:0] a_data, b_data;
    logic              a_ready, b_ready, y_valid, y_last, sel, busy;
    logic [DATA_W-1:0] y_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    stream_mux_2to1 #(.DATA_W(DATA_W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .a_valid (a_valid),
        .a_data  (a_data),
        .a_last  (a_last),
        .a_ready (a_ready),
        .b_valid (b_valid),
        .b_data  (b_data),
        .b_last  (b_last),
        .b_ready (b_ready),
        .y_valid (y_valid),
        .y_data  (y_data),
        .y_last  (y_last),
        .y_ready (y_ready),
        .sel     (sel),
        .busy    (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input int av, input int ad, input int al,
                         input int bv, input int bd, input int bl, input int yr);
        a_valid = (av != 0);
        a_data  = ad[7:0];
        a_last  = (al != 0);
        b_valid = (bv != 0);
        b_data  = bd[7:0];
        b_last  = (bl != 0);
        y_ready = (yr != 0);
        $display("drive a=%0d/%02h/%0d b=%0d/%02h/%0d yr=%0d", av, ad, al, bv, bd, bl, yr);
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Directed table: inputs for one cycle plus the readies seen in that
    // cycle and the registered output present before the edge.
    typedef struct {
        int rst; int av; int ad; int al; int bv; int bd; int bl; int yr;
        int ear; int ebr; int eyv; int eyd; int eyl; int esel; int ebusy;
    } vec_t;
    vec_t vecs[NV];

    // Reference model state for random traffic.
    bit          m_rr;
    int          m_owner;            // 0 none, 1 A, 2 B
    bit          p_hs, p_src, p_last, p_yv, p_yr, p_yl, p_sel;
    logic [7:0]  p_data, p_yd;
    bit          a_acc, b_acc;
    int          n_in, n_out;

    task automatic model_reset();
        m_rr = 1'b0; m_owner = 0;
        p_hs = 1'b0; p_yv = 1'b0; p_yr = 1'b0;
        p_src = 1'b0; p_last = 1'b0; p_data = '0;
        p_yd = '0; p_yl = 1'b0; p_sel = 1'b0;
        a_acc = 1'b0; b_acc = 1'b0;
        n_in = 0; n_out = 0;
    endtask

    task automatic rand_cycle(input bit gen, input int cyc);
        bit         exp_yv, load_ok, both, gsrc, ea, eb;
        logic [7:0] cur_yd;
        bit         cur_yl, cur_sel;
        if (!gen) begin
            a_valid = 1'b0; b_valid = 1'b0; y_ready = 1'b1;
        end else begin
            if (!a_valid || a_acc) begin
                a_valid = ($urandom_range(0, 99) < 60);
                a_data  = 8'($urandom);
                a_last  = ($urandom_range(0, 2) == 0);
            end
            if (!b_valid || b_acc) begin
                b_valid = ($urandom_range(0, 99) < 60);
                b_data  = 8'($urandom);
                b_last  = ($urandom_range(0, 2) == 0);
            end
            y_ready = ($urandom_range(0, 99) < 70);
        end
        @(negedge clk);
        // Output register: new beat one cycle after acceptance, else held until drained.
        exp_yv  = p_hs || (p_yv && !p_yr);
        cur_yd  = p_hs ? p_data : p_yd;
        cur_yl  = p_hs ? p_last : p_yl;
        cur_sel = p_hs ? p_src  : p_sel;
        chk($sformatf("rnd%0d y_valid", cyc), y_valid, exp_yv);
        if (exp_yv) begin
            chk($sformatf("rnd%0d y_data", cyc), y_data, cur_yd);
            chk($sformatf("rnd%0d y_last", cyc), y_last, cur_yl);
            chk($sformatf("rnd%0d sel", cyc), sel, cur_sel);
        end
        chk($sformatf("rnd%0d busy", cyc), busy, (m_owner != 0));
        load_ok = !exp_yv || y_ready;
        ea = 1'b0; eb = 1'b0;
        if (m_owner == 1) ea = load_ok;
        else if (m_owner == 2) eb = load_ok;
        else if (a_valid || b_valid) begin
            both = a_valid && b_valid;
            gsrc = both ? m_rr : b_valid;
            if (gsrc) eb = load_ok; else ea = load_ok;
        end
        chk($sformatf("rnd%0d a_ready", cyc), a_ready, ea);
        chk($sformatf("rnd%0d b_ready", cyc), b_ready, eb);
        chk($sformatf("rnd%0d ready_excl", cyc), (a_ready && b_ready), 1'b0);
        a_acc = a_valid && ea;
        b_acc = b_valid && eb;
        if (a_acc) begin
            if (a_last) begin m_owner = 0; m_rr = 1'b1; end else m_owner = 1;
        end
        if (b_acc) begin
            if (b_last) begin m_owner = 0; m_rr = 1'b0; end else m_owner = 2;
        end
        if (a_acc || b_acc) n_in++;
        if (exp_yv && y_ready) n_out++;
        p_yd = cur_yd; p_yl = cur_yl; p_sel = cur_sel;
        p_yv = exp_yv; p_yr = y_ready;
        p_hs = a_acc || b_acc;
        p_src = b_acc;
        p_data = b_acc ? b_data : a_data;
        p_last = b_acc ? b_last : a_last;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{0,1,'h11,1,0,'h00,0,1, 1,0,0,'h00,0,0,0};
        vecs[1]  = '{0,1,'h22,1,0,'h00,0,1, 1,0,1,'h11,1,0,0};
        vecs[2]  = '{0,1,'h33,1,0,'h00,0,1, 1,0,1,'h22,1,0,0};
        vecs[3]  = '{0,0,'h00,0,0,'h00,0,1, 0,0,1,'h33,1,0,0};
        vecs[4]  = '{1,1,'hA0,1,1,'hB0,1,1, 1,0,0,'h00,0,0,0};
        vecs[5]  = '{0,1,'hA1,1,1,'hB0,1,1, 0,1,1,'hA0,1,0,0};
        vecs[6]  = '{0,1,'hA1,1,1,'hB1,1,1, 1,0,1,'hB0,1,1,0};
        vecs[7]  = '{0,1,'hA2,1,1,'hB1,1,1, 0,1,1,'hA1,1,0,0};
        vecs[8]  = '{0,0,'h00,0,0,'h00,0,1, 0,0,1,'hB1,1,1,0};
        vecs[9]  = '{0,0,'h00,0,0,'h00,0,1, 0,0,0,'h00,0,1,0};
        vecs[10] = '{1,1,'hC1,0,1,'hD0,1,1, 1,0,0,'h00,0,0,0};
        vecs[11] = '{0,1,'hC2,0,1,'hD0,1,1, 1,0,1,'hC1,0,0,1};
        vecs[12] = '{0,1,'hC3,1,1,'hD0,1,1, 1,0,1,'hC2,0,0,1};
        vecs[13] = '{0,0,'h00,0,1,'hD0,1,1, 0,1,1,'hC3,1,0,0};
        for (int i = 14; i < 18; i++)
            vecs[i] = '{0,1,'hE1,1,0,'h00,0,0, 0,0,1,'hD0,1,1,0};
        vecs[18] = '{0,1,'hE1,1,0,'h00,0,1, 1,0,1,'hD0,1,1,0};
        vecs[19] = '{0,0,'h00,0,0,'h00,0,1, 0,0,1,'hE1,1,0,0};
        vecs[20] = '{0,0,'h00,0,0,'h00,0,1, 0,0,0,'h00,0,0,0};

        // Reset state, with both sources requesting.
        drive(1, 'h55, 1, 1, 'h66, 1, 1);
        #12;
        chk("rst a_ready", a_ready, 1'b0);
        chk("rst b_ready", b_ready, 1'b0);
        chk("rst y_valid", y_valid, 1'b0);
        chk("rst y_data",  y_data,  8'h00);
        chk("rst y_last",  y_last,  1'b0);
        chk("rst sel",     sel,     1'b0);
        chk("rst busy",    busy,    1'b0);
        do_reset();

        for (int i = 0; i < NV; i++) begin
            if (vecs[i].rst != 0) do_reset();
            drive(vecs[i].av, vecs[i].ad, vecs[i].al, vecs[i].bv, vecs[i].bd, vecs[i].bl, vecs[i].yr);
            @(negedge clk);
            chk($sformatf("v%0d a_ready", i), a_ready, vecs[i].ear);
            chk($sformatf("v%0d b_ready", i), b_ready, vecs[i].ebr);
            chk($sformatf("v%0d y_valid", i), y_valid, vecs[i].eyv);
            chk($sformatf("v%0d sel", i),     sel,     vecs[i].esel);
            chk($sformatf("v%0d busy", i),    busy,    vecs[i].ebusy);
            if (vecs[i].eyv != 0) begin
                chk($sformatf("v%0d y_data", i), y_data, vecs[i].eyd);
                chk($sformatf("v%0d y_last", i), y_last, vecs[i].eyl);
            end
            @(posedge clk);
            #1;
        end

        // Bubble inside an A packet while B waits.
        do_reset();
        drive(1, 'hF1, 0, 1, 'h60, 1, 1);
        @(negedge clk);
        chk("bub0 a_ready", a_ready, 1'b1);
        chk("bub0 b_ready", b_ready, 1'b0);
        @(posedge clk); #1;
        drive(0, 'h00, 0, 1, 'h60, 1, 1);
        @(negedge clk);
        chk("bub1 busy", busy, 1'b1);
        chk("bub1 b_ready", b_ready, 1'b0);
        chk("bub1 y_data", y_data, 8'hF1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("bub2 busy", busy, 1'b1);
        chk("bub2 b_ready", b_ready, 1'b0);
        chk("bub2 y_valid", y_valid, 1'b0);
        @(posedge clk); #1;
        drive(1, 'hF2, 1, 1, 'h60, 1, 1);
        @(negedge clk);
        chk("bub3 a_ready", a_ready, 1'b1);
        chk("bub3 b_ready", b_ready, 1'b0);
        @(posedge clk); #1;
        drive(0, 'h00, 0, 1, 'h60, 1, 1);
        @(negedge clk);
        chk("bub4 y_data", y_data, 8'hF2);
        chk("bub4 y_last", y_last, 1'b1);
        chk("bub4 b_ready", b_ready, 1'b1);
        chk("bub4 busy", busy, 1'b0);
        @(posedge clk); #1;
        drive(0, 'h00, 0, 0, 'h00, 0, 1);
        @(negedge clk);
        chk("bub5 y_data", y_data, 8'h60);
        chk("bub5 sel", sel, 1'b1);
        @(posedge clk); #1;

        // Asynchronous reset in the middle of a B packet.
        do_reset();
        drive(0, 'h00, 0, 1, 'h71, 0, 1);
        @(posedge clk); #1;
        drive(0, 'h00, 0, 1, 'h72, 0, 1);
        @(negedge clk);
        chk("arst lock busy", busy, 1'b1);
        chk("arst lock sel", sel, 1'b1);
        @(posedge clk); #1;
        drive(1, 'h81, 1, 1, 'h91, 1, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst y_valid", y_valid, 1'b0);
        chk("arst sel", sel, 1'b0);
        chk("arst busy", busy, 1'b0);
        chk("arst a_ready", a_ready, 1'b0);
        chk("arst b_ready", b_ready, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("arst post a_ready", a_ready, 1'b1);
        chk("arst post b_ready", b_ready, 1'b0);
        @(posedge clk); #1;
        chk("arst post y_data", y_data, 8'h81);
        chk("arst post sel", sel, 1'b0);
        drive(0, 'h00, 0, 0, 'h00, 0, 1);

        // Random traffic against the reference model, then a drain.
        do_reset();
        model_reset();
        for (int c = 0; c < NRAND; c++) rand_cycle(1'b1, c);
        for (int c = 0; c < 4; c++) rand_cycle(1'b0, NRAND + c);
        chk("rnd beats in vs out", n_out, n_in);
        $display("random phase: %0d beats accepted, %0d beats delivered", n_in, n_out);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
